// File: rtl/trap_pkg.sv
// Shared definitions for the trap controller: FSM encoding, CSR addresses and the cause offset.
package trap_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SAVE    = 2'd1;
  localparam logic [1:0] ST_HANDLER = 2'd2;
  localparam logic [1:0] ST_RELOAD  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    SAVE    = ST_SAVE,
    HANDLER = ST_HANDLER,
    RELOAD  = ST_RELOAD
  } state_t;

  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MIP     = 12'h344;
  localparam logic [11:0] CSR_TRAPCNT = 12'h7C0;

  // mcause reports source index + 1 so that 0 can mean "no trap".
  localparam int CAUSE_OFFSET = 1;

endpackage

// File: rtl/trap_prio_enc.sv
// Lowest-index-wins priority encoder; index 0 is the highest priority source.
module trap_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0]                          req,
  output logic                                  valid,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]  idx
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  always_comb begin
    valid = |req;
    idx   = '0;
    // Scan downward so the lowest set index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap/interrupt controller: latches trap CSRs, redirects to a per-source vector and back on mret.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int                  XLEN          = 32,
  parameter int                  NUM_SRC       = 8,
  parameter logic [XLEN-1:0]     VEC_BASE      = XLEN'(32'h0000F000),
  parameter int                  VEC_STRIDE    = 4,
  parameter logic [NUM_SRC-1:0]  EPC_NEXT_MASK = {{(NUM_SRC-1){1'b0}}, 1'b1},
  parameter logic [NUM_SRC-1:0]  NMI_MASK      = {{(NUM_SRC-1){1'b0}}, 1'b1}
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NUM_SRC-1:0]      trap_req,
  input  logic [NUM_SRC*XLEN-1:0] trap_tval,
  input  logic [XLEN-1:0]         ex_pc,
  input  logic                    mret,
  input  logic [11:0]             csr_raddr,
  output logic [XLEN-1:0]         csr_rdata,
  input  logic                    csr_we,
  input  logic [11:0]             csr_waddr,
  input  logic [XLEN-1:0]         csr_wdata,
  output logic                    redirect_valid,
  output logic [XLEN-1:0]         redirect_pc,
  output logic                    flush,
  output logic                    stall,
  output logic                    in_trap
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  state_t               state;
  logic [NUM_SRC-1:0]   mie, mip, pend, elig, win_onehot;
  logic [XLEN-1:0]      mtvec, mepc, mcause, mtval, trapcnt;
  logic                 win_valid, take, mepc_we, mie_we;
  logic [IW-1:0]        win_idx;
  logic [XLEN-1:0]      win_vec, win_epc, win_tval, mepc_next;

  // A request that arrives in the capture cycle must be visible to selection immediately.
  assign pend = mip | trap_req;
  assign elig = pend & (mie | NMI_MASK);

  trap_prio_enc #(.N(NUM_SRC)) u_prio_enc (
    .req   (elig),
    .valid (win_valid),
    .idx   (win_idx)
  );

  assign take       = (state == IDLE) && win_valid;
  assign win_onehot = take ? (NUM_SRC'(1) << win_idx) : '0;
  assign win_vec    = VEC_BASE + XLEN'(win_idx) * XLEN'(VEC_STRIDE);
  assign win_epc    = ex_pc + (EPC_NEXT_MASK[win_idx] ? XLEN'(4) : '0);
  assign win_tval   = trap_tval[win_idx*XLEN +: XLEN];

  assign mepc_we   = csr_we && (csr_waddr == CSR_MEPC);
  assign mie_we    = csr_we && (csr_waddr == CSR_MIE);
  // Capture has priority over a software write landing on the same edge.
  assign mepc_next = take ? win_epc : (mepc_we ? csr_wdata : mepc);

  always_comb begin
    csr_rdata = '0;
    case (csr_raddr)
      CSR_MIE:     csr_rdata = XLEN'(mie);
      CSR_MTVEC:   csr_rdata = mtvec;
      CSR_MEPC:    csr_rdata = mepc;
      CSR_MCAUSE:  csr_rdata = mcause;
      CSR_MTVAL:   csr_rdata = mtval;
      CSR_MIP:     csr_rdata = XLEN'(mip);
      CSR_TRAPCNT: csr_rdata = trapcnt;
      default:     csr_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      mie            <= '1;
      mip            <= '0;
      mepc           <= '0;
      mcause         <= '0;
      mtval          <= '0;
      trapcnt        <= '0;
      mtvec          <= VEC_BASE;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      stall          <= 1'b0;
      in_trap        <= 1'b0;
    end else begin
      mip            <= pend & ~win_onehot;
      mepc           <= mepc_next;
      if (mie_we) mie <= csr_wdata[NUM_SRC-1:0];
      redirect_valid <= 1'b0;
      flush          <= 1'b0;
      stall          <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            mcause         <= XLEN'(win_idx) + XLEN'(CAUSE_OFFSET);
            mtval          <= win_tval;
            mtvec          <= win_vec;
            trapcnt        <= trapcnt + XLEN'(1);
            state          <= SAVE;
            redirect_valid <= 1'b1;
            redirect_pc    <= win_vec;
            flush          <= 1'b1;
            stall          <= 1'b1;
            in_trap        <= 1'b1;
          end
        end
        SAVE: state <= HANDLER;
        HANDLER: begin
          if (mret) begin
            state          <= RELOAD;
            redirect_valid <= 1'b1;
            redirect_pc    <= mepc_next;
            flush          <= 1'b1;
            stall          <= 1'b1;
          end
        end
        RELOAD: begin
          state   <= IDLE;
          in_trap <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          in_trap <= 1'b0;
        end
      endcase
    end
  end

endmodule
